// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the multi-cycle RISC-V sequencing controller
//
// Purpose: state enum, supported opcodes, datapath select encodings and the
//          one-hot immediate-type constants used by multicycle_ctrl and
//          mc_ctrl_decode.
// Ports:   none (package).
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] SRCA_RS1   = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_PC    = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // One-hot {J,U,B,S,I}
  localparam logic [4:0] IMM_NONE = 5'b00000;
  localparam logic [4:0] IMM_I    = 5'b00001;
  localparam logic [4:0] IMM_S    = 5'b00010;
  localparam logic [4:0] IMM_B    = 5'b00100;
  localparam logic [4:0] IMM_U    = 5'b01000;
  localparam logic [4:0] IMM_J    = 5'b10000;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI: is_legal = 1'b1;
      default:                                                  is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] imm_for(input logic [6:0] op);
    case (op)
      OP_I, OP_LOAD: imm_for = IMM_I;
      OP_STORE:      imm_for = IMM_S;
      OP_BRANCH:     imm_for = IMM_B;
      OP_LUI:        imm_for = IMM_U;
      OP_JAL:        imm_for = IMM_J;
      default:       imm_for = IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational state+opcode to datapath strobe mapping
//
// Purpose: Moore-style output decode of the sequencing FSM. Only the memory
//          handshake (FETCH/MEM completion) and the branch outcome look at
//          live inputs.
// Ports:   state/opcode/funct3_lsb/zero/mem_ready in; every datapath strobe,
//          select, imm_type and the fetch/retire/illegal flags out.
module mc_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] opcode,
  input  logic       funct3_lsb,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [4:0] imm_type,
  output logic       fetch,
  output logic       retire,
  output logic       illegal
);

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_RS1;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    result_src = RES_ALUOUT;
    imm_type   = IMM_NONE;
    fetch      = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        fetch     = 1'b1;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_FOUR;
        // PC+4 goes straight from the ALU into the PC as the word lands in IR.
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_DECODE: begin
        // Speculative branch/jump target OldPC+imm parks in ALUOut.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_type  = imm_for(opcode);
      end
      S_EXEC: begin
        imm_type = imm_for(opcode);
        case (opcode)
          OP_R: begin
            alu_op = ALUOP_RFUNCT;
          end
          OP_I: begin
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_IFUNCT;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b = SRCB_IMM;
          end
          OP_LUI: begin
            alu_src_a = SRCA_ZERO;
            alu_src_b = SRCB_IMM;
          end
          OP_BRANCH: begin
            alu_op   = ALUOP_SUB;
            // funct3[0] distinguishes BNE from BEQ.
            pc_write = zero ^ funct3_lsb;
            pc_src   = 1'b1;
            retire   = 1'b1;
          end
          OP_JAL: begin
            // Target comes from ALUOut; the ALU meanwhile forms the link value.
            pc_write  = 1'b1;
            pc_src    = 1'b1;
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        imm_type = imm_for(opcode);
        mem_req  = 1'b1;
        adr_src  = 1'b1;
        mem_we   = (opcode == OP_STORE);
        retire   = mem_ready && (opcode == OP_STORE);
      end
      S_WB: begin
        reg_write  = 1'b1;
        result_src = (opcode == OP_LOAD) ? RES_MDR : RES_ALUOUT;
        retire     = 1'b1;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RISC-V sequencing controller top
//
// Purpose: holds the FSM state register, next-state logic and the retired
//          instruction counter; strobes come from mc_ctrl_decode.
// Ports:   iCPU_Clk/iCPU_Reset clock and async active-low reset;
//          iOpcode/iFunct3/iZero from IR and ALU; iMemReady/iHalt handshake
//          and debugger halt; o* datapath strobes/selects, status flags,
//          oState watch value and oInstrCount retire count.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic        iCPU_Clk,
  input  logic        iCPU_Reset,
  input  logic [6:0]  iOpcode,
  input  logic [2:0]  iFunct3,
  input  logic        iZero,
  input  logic        iMemReady,
  input  logic        iHalt,
  output logic        oMemReq,
  output logic        oMemWE,
  output logic        oAdrSrc,
  output logic        oIRWrite,
  output logic        oPCWrite,
  output logic        oPCSrc,
  output logic        oRegWrite,
  output logic [1:0]  oALUSrcA,
  output logic [1:0]  oALUSrcB,
  output logic [1:0]  oALUop,
  output logic [1:0]  oResultSrc,
  output logic [4:0]  oImm_type,
  output logic        oFetch,
  output logic        oRetire,
  output logic        oIllegal,
  output logic [2:0]  oState,
  output logic [31:0] oInstrCount
);

  state_t      state;
  state_t      next_state;
  logic        retire;
  logic [31:0] instr_count;
  logic        unused_funct3;

  // Only BEQ/BNE are sequenced, so funct3[2:1] carries no control meaning.
  assign unused_funct3 = ^iFunct3[2:1];

  always_ff @(posedge iCPU_Clk or negedge iCPU_Reset) begin
    if (!iCPU_Reset) begin
      state <= S_HALT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_HALT:   if (!iHalt) next_state = S_FETCH;
      S_FETCH:  if (iMemReady) next_state = S_DECODE;
      S_DECODE: next_state = is_legal(iOpcode) ? S_EXEC : S_TRAP;
      S_EXEC:   next_state = (iOpcode == OP_LOAD || iOpcode == OP_STORE) ? S_MEM : S_WB;
      S_MEM:    if (iMemReady && iOpcode == OP_LOAD) next_state = S_WB;
      S_WB:     next_state = S_WB;
      S_TRAP:   next_state = S_TRAP;
      default:  next_state = S_HALT;
    endcase
    // Every retire cycle is an instruction boundary: the only place iHalt can stop the core.
    if (retire) next_state = iHalt ? S_HALT : S_FETCH;
  end

  always_ff @(posedge iCPU_Clk or negedge iCPU_Reset) begin
    if (!iCPU_Reset) begin
      instr_count <= 32'd0;
    end else if (retire) begin
      instr_count <= instr_count + 32'd1;
    end
  end

  mc_ctrl_decode u_decode (
    .state      (state),
    .opcode     (iOpcode),
    .funct3_lsb (iFunct3[0]),
    .zero       (iZero),
    .mem_ready  (iMemReady),
    .mem_req    (oMemReq),
    .mem_we     (oMemWE),
    .adr_src    (oAdrSrc),
    .ir_write   (oIRWrite),
    .pc_write   (oPCWrite),
    .pc_src     (oPCSrc),
    .reg_write  (oRegWrite),
    .alu_src_a  (oALUSrcA),
    .alu_src_b  (oALUSrcB),
    .alu_op     (oALUop),
    .result_src (oResultSrc),
    .imm_type   (oImm_type),
    .fetch      (oFetch),
    .retire     (retire),
    .illegal    (oIllegal)
  );

  assign oRetire     = retire;
  assign oState      = state;
  assign oInstrCount = instr_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        halt = 1'b0;
  logic        oMemReq, oMemWE, oAdrSrc, oIRWrite, oPCWrite, oPCSrc, oRegWrite;
  logic [1:0]  oALUSrcA, oALUSrcB, oALUop, oResultSrc;
  logic [4:0]  oImm_type;
  logic        oFetch, oRetire, oIllegal;
  logic [2:0]  oState;
  logic [31:0] oInstrCount;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_cnt = 32'd0;

  multicycle_ctrl dut (
    .iCPU_Clk    (clk),
    .iCPU_Reset  (rst_n),
    .iOpcode     (opcode),
    .iFunct3     (funct3),
    .iZero       (zero),
    .iMemReady   (mem_ready),
    .iHalt       (halt),
    .oMemReq     (oMemReq),
    .oMemWE      (oMemWE),
    .oAdrSrc     (oAdrSrc),
    .oIRWrite    (oIRWrite),
    .oPCWrite    (oPCWrite),
    .oPCSrc      (oPCSrc),
    .oRegWrite   (oRegWrite),
    .oALUSrcA    (oALUSrcA),
    .oALUSrcB    (oALUSrcB),
    .oALUop      (oALUop),
    .oResultSrc  (oResultSrc),
    .oImm_type   (oImm_type),
    .oFetch      (oFetch),
    .oRetire     (oRetire),
    .oIllegal    (oIllegal),
    .oState      (oState),
    .oInstrCount (oInstrCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    all_outs = {4'd0, oMemReq, oMemWE, oAdrSrc, oIRWrite, oPCWrite, oPCSrc, oRegWrite,
                oALUSrcA, oALUSrcB, oALUop, oResultSrc, oImm_type, oFetch, oRetire,
                oIllegal, oState};
  endfunction

  // One instruction from its first FETCH cycle through its retire cycle, with a
  // memory that answers after wfetch / wmem wait cycles.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic z, input int wfetch, input int wmem, input bit halt_exec);
    bit          is_ld, is_st, is_br, is_jal, is_mem, writes, taken, rs_ok, sel_ok, done;
    logic [5:0]  exp_sel, obs_sel;
    logic [4:0]  exp_imm, obs_imm;
    logic [63:0] exp_tr, obs_tr;
    int          exp_cycles, cycles, req, n_req, n_we, n_rw, n_pcw, n_irw, n_ret;
    is_ld  = (op == 7'b0000011);
    is_st  = (op == 7'b0100011);
    is_br  = (op == 7'b1100011);
    is_jal = (op == 7'b1101111);
    is_mem = is_ld || is_st;
    writes = !(is_st || is_br);
    taken  = (f3[0] == 1'b0) ? z : !z;
    case (op)
      7'b0110011: begin exp_sel = 6'b00_00_10; exp_imm = 5'b00000; end
      7'b0010011: begin exp_sel = 6'b00_01_11; exp_imm = 5'b00001; end
      7'b0000011: begin exp_sel = 6'b00_01_00; exp_imm = 5'b00001; end
      7'b0100011: begin exp_sel = 6'b00_01_00; exp_imm = 5'b00010; end
      7'b1100011: begin exp_sel = 6'b00_00_01; exp_imm = 5'b00100; end
      7'b1101111: begin exp_sel = 6'b01_10_00; exp_imm = 5'b10000; end
      default:    begin exp_sel = 6'b11_01_00; exp_imm = 5'b01000; end
    endcase
    exp_cycles = (is_br ? 3 : (is_ld ? 5 : 4)) + wfetch + (is_mem ? wmem : 0);
    exp_tr = 64'd0;
    for (int i = 0; i <= wfetch; i++) exp_tr = (exp_tr << 3) | 64'd1;
    exp_tr = (exp_tr << 3) | 64'd2;
    exp_tr = (exp_tr << 3) | 64'd3;
    if (is_mem) for (int i = 0; i <= wmem; i++) exp_tr = (exp_tr << 3) | 64'd4;
    if (writes) exp_tr = (exp_tr << 3) | 64'd5;

    obs_tr = 64'd0; obs_sel = 6'd0; obs_imm = 5'd0;
    cycles = 0; req = 0; n_req = 0; n_we = 0; n_rw = 0; n_pcw = 0; n_irw = 0; n_ret = 0;
    rs_ok = 1'b1; sel_ok = 1'b1; done = 1'b0;
    opcode = op; funct3 = f3; zero = z;
    while (!done && cycles < 40) begin
      @(negedge clk);
      mem_ready = oMemReq && (req == (oAdrSrc ? wmem : wfetch));
      if (halt_exec && oState == 3'd3) halt = 1'b1;
      #1;
      obs_tr = (obs_tr << 3) | 64'(oState);
      if (oState == 3'd2) obs_imm = oImm_type;
      if (oState == 3'd3) obs_sel = {oALUSrcA, oALUSrcB, oALUop};
      if (oState == 3'd1 && {oFetch, oAdrSrc, oALUSrcA, oALUSrcB, oALUop} !== 8'b1_0_10_10_00) sel_ok = 1'b0;
      if (oState == 3'd4 && oAdrSrc !== 1'b1) sel_ok = 1'b0;
      if (oPCWrite && oPCSrc !== (oState == 3'd3)) sel_ok = 1'b0;
      if (oIllegal) sel_ok = 1'b0;
      if (oRegWrite && (oState !== 3'd5 || oResultSrc !== (is_ld ? 2'b01 : 2'b00))) rs_ok = 1'b0;
      if (oMemReq)   n_req++;
      if (oMemWE)    n_we++;
      if (oRegWrite) n_rw++;
      if (oPCWrite)  n_pcw++;
      if (oIRWrite)  n_irw++;
      if (oRetire)   n_ret++;
      if (oMemReq) req = mem_ready ? 0 : req + 1;
      else         req = 0;
      if (oRetire) done = 1'b1;
      cycles++;
    end
    check({name, ".retired"}, 32'(done), 32'd1);
    check({name, ".cycles"}, cycles, exp_cycles);
    check({name, ".trace_lo"}, obs_tr[31:0], exp_tr[31:0]);
    check({name, ".trace_hi"}, obs_tr[63:32], exp_tr[63:32]);
    check({name, ".memreq_cycles"}, n_req, 1 + wfetch + (is_mem ? 1 + wmem : 0));
    check({name, ".memwe_cycles"}, n_we, is_st ? 1 + wmem : 0);
    check({name, ".regwrite_cycles"}, n_rw, writes ? 1 : 0);
    check({name, ".pcwrite_cycles"}, n_pcw, 1 + (is_jal ? 1 : 0) + ((is_br && taken) ? 1 : 0));
    check({name, ".irwrite_cycles"}, n_irw, 1);
    check({name, ".retire_cycles"}, n_ret, 1);
    check({name, ".wb_result_src"}, 32'(rs_ok), 32'd1);
    check({name, ".fetch_mem_sel"}, 32'(sel_ok), 32'd1);
    check({name, ".exec_sel"}, 32'(obs_sel), 32'(exp_sel));
    check({name, ".decode_imm"}, 32'(obs_imm), 32'(exp_imm));
    model_cnt = model_cnt + 32'd1;
    @(posedge clk);
    #1;
    check({name, ".next_state"}, 32'(oState), halt ? 32'd0 : 32'd1);
    check({name, ".instr_count"}, oInstrCount, model_cnt);
  endtask

  logic [6:0] ops [7];
  int         bad;
  logic [8:0] trap_tr;

  initial begin
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
    ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b0110111;

    // Reset state and first request one cycle after release.
    repeat (2) @(negedge clk);
    #1;
    check("reset.outputs", all_outs(), 32'd0);
    check("reset.count", oInstrCount, 32'd0);
    rst_n = 1'b1;
    #1;
    check("release.state", 32'(oState), 32'd0);
    check("release.memreq", 32'(oMemReq), 32'd0);
    @(posedge clk);
    #1;
    check("first_fetch.memreq", 32'(oMemReq), 32'd1);

    // Directed instructions.
    run_instr("addi", 7'b0010011, 3'b000, 1'b0, 0, 0, 1'b0);
    run_instr("lw_wait3", 7'b0000011, 3'b010, 1'b0, 0, 3, 1'b0);
    run_instr("beq_taken", 7'b1100011, 3'b000, 1'b1, 0, 0, 1'b0);
    run_instr("bne_not_taken", 7'b1100011, 3'b001, 1'b1, 0, 0, 1'b0);

    // Halt raised during EXEC of a store takes effect only after it retires.
    run_instr("sw_halt", 7'b0100011, 3'b010, 1'b0, 0, 1, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("halt.held_state", 32'(oState), 32'd0);
    check("halt.held_outputs", all_outs(), 32'd0);
    halt = 1'b0;
    @(posedge clk);
    #1;
    check("halt.release_fetch", 32'(oState), 32'd1);

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      int k;
      logic [2:0] f;
      k = $urandom_range(0, 6);
      f = (k == 4) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      run_instr($sformatf("rnd%0d", n), ops[k], f, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    // Counter wraps from all-ones to zero.
    force dut.instr_count = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count;
    check("wrap.preload", oInstrCount, 32'hFFFF_FFFF);
    model_cnt = 32'hFFFF_FFFF;
    run_instr("wrap_add", 7'b0110011, 3'b000, 1'b0, 1, 0, 1'b0);

    // Illegal opcode traps and sticks until reset.
    opcode = 7'h7F;
    trap_tr = 9'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = oMemReq;
      #1;
      trap_tr = {trap_tr[5:0], oState};
    end
    check("trap.trace", 32'(trap_tr), 32'(9'b001_010_110));
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (!(oIllegal === 1'b1 && oState === 3'd6 && oRetire === 1'b0 && oMemReq === 1'b0)) bad++;
    end
    check("trap.held_100", bad, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("trap_reset.outputs", all_outs(), 32'd0);
    check("trap_reset.count", oInstrCount, 32'd0);

    // Reset in the middle of a stalled fetch drops the request immediately.
    mem_ready = 1'b0;
    opcode = 7'b0110011;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    repeat (2) @(negedge clk);
    #1;
    check("fetch_wait.memreq", 32'(oMemReq), 32'd1);
    check("fetch_wait.state", 32'(oState), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("fetch_wait_reset.outputs", all_outs(), 32'd0);
    check("fetch_wait_reset.count", oInstrCount, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
